// File: rtl/uart_boot_loader_if.sv
// Byte-stream and Wishbone request signals between the boot loader and its peers.
// The loader takes the master modport; the UART/bus side takes the slave modport.
interface uart_boot_loader_if #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_SEL_WIDTH  = 4
);
  logic [7:0]               rx_data_i;
  logic                     rx_valid_i;
  logic                     rx_ready_o;
  logic [WB_ADDR_WIDTH-1:0] wb_addr_o;
  logic [WB_DATA_WIDTH-1:0] wb_data_o;
  logic [WB_SEL_WIDTH-1:0]  wb_sel_o;
  logic                     wb_we_o;
  logic                     wb_stb_o;
  logic                     wb_cyc_o;
  logic                     wb_ack_i;

  modport master (
    input  rx_data_i, rx_valid_i, wb_ack_i,
    output rx_ready_o, wb_addr_o, wb_data_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, wb_ack_i,
    input  rx_ready_o, wb_addr_o, wb_data_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o
  );
endinterface

// File: rtl/uart_boot_loader.sv
// Receives a framed image over a UART byte stream and writes it word by word
// onto Wishbone while holding the CPU in reset.
module uart_boot_loader #(
  parameter int         WB_DATA_WIDTH = 32,
  parameter int         WB_ADDR_WIDTH = 32,
  parameter int         WB_SEL_WIDTH  = 4,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         ACK_TIMEOUT   = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  uart_boot_loader_if.master  bus,
  output logic                cpu_rst_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] LEN   = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERR   = 3'd6;

  logic [2:0]               state_reg, state_next;
  logic [1:0]               cnt_reg, cnt_next;
  logic [23:0]              shift_reg, shift_next;
  logic [WB_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [WB_DATA_WIDTH-1:0] word_reg, word_next;
  logic [15:0]              remain_reg, remain_next;
  logic [TW-1:0]            timer_reg, timer_next;
  logic                     ready_reg, req_reg, done_reg, err_reg, cpu_rst_reg;
  logic [WB_SEL_WIDTH-1:0]  sel_reg;
  logic                     take;
  logic [31:0]              shifted;

  assign take    = bus.rx_valid_i & ready_reg;
  // Bytes arrive LSB first, so each new byte enters at the top and older ones slide down.
  assign shifted = {bus.rx_data_i, shift_reg};

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shift_next  = shift_reg;
    addr_next   = addr_reg;
    word_next   = word_reg;
    remain_next = remain_reg;
    timer_next  = timer_reg;
    case (state_reg)
      IDLE, ERR: begin
        if (take && bus.rx_data_i == SYNC_BYTE) begin
          state_next = ADDR;
          cnt_next   = 2'd0;
        end
      end
      ADDR: begin
        if (take) begin
          shift_next = shifted[31:8];
          cnt_next   = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            addr_next  = {shifted[WB_ADDR_WIDTH-1:2], 2'b00};
            state_next = LEN;
          end
        end
      end
      LEN: begin
        if (take) begin
          shift_next = shifted[31:8];
          cnt_next   = cnt_reg + 2'd1;
          if (cnt_reg == 2'd1) begin
            remain_next = shifted[31:16];
            cnt_next    = 2'd0;
            state_next  = (shifted[31:16] == 16'd0) ? DONE : DATA;
          end
        end
      end
      DATA: begin
        if (take) begin
          shift_next = shifted[31:8];
          cnt_next   = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            word_next  = shifted[WB_DATA_WIDTH-1:0];
            timer_next = '0;
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        // An ack on the final allowed cycle still completes the write.
        if (bus.wb_ack_i) begin
          addr_next   = addr_reg + WB_ADDR_WIDTH'(4);
          remain_next = remain_reg - 16'd1;
          state_next  = (remain_reg == 16'd1) ? DONE : DATA;
        end else if (timer_reg == TW'(ACK_TIMEOUT - 1)) begin
          state_next = ERR;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      DONE: state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= 2'd0;
      shift_reg   <= '0;
      addr_reg    <= '0;
      word_reg    <= '0;
      remain_reg  <= '0;
      timer_reg   <= '0;
      ready_reg   <= 1'b0;
      req_reg     <= 1'b0;
      sel_reg     <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      cpu_rst_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      addr_reg    <= addr_next;
      word_reg    <= word_next;
      remain_reg  <= remain_next;
      timer_reg   <= timer_next;
      ready_reg   <= (state_next != WRITE) && (state_next != DONE);
      req_reg     <= (state_next == WRITE);
      sel_reg     <= {WB_SEL_WIDTH{state_next == WRITE}};
      done_reg    <= (state_next == DONE);
      err_reg     <= (state_next == ERR);
      cpu_rst_reg <= (state_next != DONE);
    end
  end

  assign bus.rx_ready_o = ready_reg;
  assign bus.wb_cyc_o   = req_reg;
  assign bus.wb_stb_o   = req_reg;
  assign bus.wb_we_o    = req_reg;
  assign bus.wb_sel_o   = sel_reg;
  assign bus.wb_addr_o  = addr_reg;
  assign bus.wb_data_o  = word_reg;
  assign cpu_rst_o      = cpu_rst_reg;
  assign done_o         = done_reg;
  assign err_o          = err_reg;

endmodule
